// File: rtl/sa_sched.sv
// ---------------------------------------------------------------------------
// sa_sched -- issue scheduler and result buffer for the SIZE x SIZE systolic
// array `sa`.
//
// Accepts weight-load / compute commands over a valid/ready slave port,
// drives the array for one cycle per command, then holds off further issues
// for the spacing the array needs. Every compute reserves a result-buffer
// slot before it is issued, because the array cannot be stalled. Results are
// queued in a DEPTH-entry FIFO and returned over a valid/ready master port.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready command handshake; s_load=1 weight load, 0 compute
//   s_matrix        command matrix
//   sa_we           array write-enable (weight load)
//   sa_matrix_vld   array matrix-valid (load or compute)
//   sa_matrix       array matrix input, holds last issued value
//   sa_res_vld      result-valid from the array
//   sa_res          result matrix from the array
//   m_valid/m_ready result handshake
//   m_matrix        head entry of the result buffer
//   o_busy          work pending anywhere in the block
//   o_err           sticky, a result arrived with nothing outstanding
// ---------------------------------------------------------------------------
module sa_sched #(
  parameter int SIZE      = 4,
  parameter int X_WIDTH   = 16,
  parameter int Y_WIDTH   = X_WIDTH * SIZE - SIZE,
  parameter int ISSUE_GAP = SIZE,
  parameter int LOAD_GAP  = 2 * SIZE,
  parameter int DEPTH     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic                                    s_load,
  input  logic [SIZE-1:0][SIZE-1:0][X_WIDTH-1:0]  s_matrix,
  output logic                                    sa_we,
  output logic                                    sa_matrix_vld,
  output logic [SIZE-1:0][SIZE-1:0][X_WIDTH-1:0]  sa_matrix,
  input  logic                                    sa_res_vld,
  input  logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0]  sa_res,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0]  m_matrix,
  output logic                                    o_busy,
  output logic                                    o_err
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int GMAX = (ISSUE_GAP > LOAD_GAP) ? ISSUE_GAP : LOAD_GAP;
  localparam int GW   = $clog2(GMAX + 1);

  typedef logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0] ymat_t;
  typedef enum logic [1:0] {IDLE, GAP, LGAP} state_t;

  state_t         state;
  logic [GW-1:0]  gap_cnt;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  count;
  logic [CW-1:0]  inflight_nxt;
  logic [CW-1:0]  count_nxt;
  logic [CW:0]    used;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  ymat_t          mem [DEPTH];

  logic accept;
  logic issue_c;
  logic push;
  logic pop;
  logic credit_ok;
  logic fsm_busy_nxt;

  // Slots already promised: results sitting in the buffer plus computes
  // whose results are still inside the array.
  assign used      = (CW+1)'(count) + (CW+1)'(inflight);
  assign credit_ok = used < (CW+1)'(DEPTH);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    s_ready = 1'b0;
    if (!rst && state == IDLE)
      s_ready = s_load ? (inflight == '0) : credit_ok;
  end

  assign accept  = s_valid & s_ready;
  assign issue_c = accept & ~s_load;
  // A result with nothing outstanding is dropped and flagged instead.
  assign push    = sa_res_vld & (inflight != '0);
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  assign m_matrix = mem[rd_ptr];

  // Issue and push in the same cycle cancel; so do push and pop.
  assign inflight_nxt = inflight + CW'(issue_c) - CW'(push);
  assign count_nxt    = count + CW'(push) - CW'(pop);

  // The FSM is still non-IDLE next cycle if a command starts a gap longer
  // than one cycle, or a running gap has more than one cycle left.
  always_comb begin
    fsm_busy_nxt = 1'b0;
    if (state == IDLE)
      fsm_busy_nxt = accept & (s_load ? (LOAD_GAP > 1) : (ISSUE_GAP > 1));
    else
      fsm_busy_nxt = (gap_cnt > GW'(1));
  end

  // Issue FSM and registered array-side outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      sa_we         <= 1'b0;
      sa_matrix_vld <= 1'b0;
      sa_matrix     <= '0;
      o_busy        <= 1'b0;
    end else begin
      sa_we         <= accept & s_load;
      sa_matrix_vld <= accept;
      if (accept)
        sa_matrix <= s_matrix;
      o_busy <= fsm_busy_nxt | (inflight_nxt != '0) | (count_nxt != '0);

      case (state)
        IDLE: begin
          if (accept && s_load && LOAD_GAP > 1) begin
            state   <= LGAP;
            gap_cnt <= GW'(LOAD_GAP - 1);
          end else if (accept && !s_load && ISSUE_GAP > 1) begin
            state   <= GAP;
            gap_cnt <= GW'(ISSUE_GAP - 1);
          end
        end
        GAP, LGAP: begin
          // Leaving on the last count makes the next acceptance land exactly
          // ISSUE_GAP / LOAD_GAP cycles after the previous one.
          if (gap_cnt <= GW'(1)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // Credit counters, buffer pointers and the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_err    <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      count    <= count_nxt;
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (sa_res_vld && inflight == '0)
        o_err <= 1'b1;
    end
  end

  // NOTE: the buffer storage has no reset; an entry is only read after it
  // has been written, and count gates m_valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= sa_res;
  end

endmodule

// File: doc/sa_sched.md
# sa_sched

Issue scheduler and result buffer for the `SIZE`x`SIZE` systolic array `sa`. It accepts weight-load and compute commands from one requester over a valid/ready handshake. Each accepted command drives the array's write-enable, matrix-valid and matrix inputs for one cycle, then enforces the spacing the array needs between issues. Because the array has no back-pressure, the block reserves a result-buffer slot for every compute before issuing it, then buffers the result matrices and returns them over a valid/ready master port.

## Interface
- `SIZE`, 4, array dimension
- `X_WIDTH`, 16, operand element width
- `Y_WIDTH`, `X_WIDTH*SIZE-SIZE`, result element width
- `ISSUE_GAP`, `SIZE`, minimum cycles between consecutive compute issues (≥1)
- `LOAD_GAP`, `2*SIZE`, cycles after a weight-load issue before any new issue (≥1)
- `DEPTH`, 4, result buffer entries (power of two, ≥2)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `s_valid`  in  1  command valid
- `s_ready`  out  1  command accepted when high with `s_valid`
- `s_load`  in  1  1 = weight load, 0 = compute
- `s_matrix`  in  `[SIZE][SIZE]` x `X_WIDTH`  command matrix
- `sa_we`  out  1  to `sa.i_we`
- `sa_matrix_vld`  out  1  to `sa.i_matrix_vld`
- `sa_matrix`  out  `[SIZE][SIZE]` x `X_WIDTH`  to `sa.i_matrix`
- `sa_res_vld`  in  1  from `sa.o_matrix_vld`
- `sa_res`  in  `[SIZE][SIZE]` x `Y_WIDTH`  from `sa.o_matrix`
- `m_valid`  out  1  result available
- `m_ready`  in  1  result consumed when high with `m_valid`
- `m_matrix`  out  `[SIZE][SIZE]` x `Y_WIDTH`  buffered result, head entry
- `o_busy`  out  1  state ≠ IDLE, or inflight ≠ 0, or buffer not empty
- `o_err`  out  1  sticky, set on unexpected `sa_res_vld`

## Operation
- **Counters**
  - `inflight`: computes issued but not yet returned, range 0..`DEPTH`.
  - `count`: buffer occupancy, range 0..`DEPTH`.
  - `credit = DEPTH - count - inflight`; it is never negative.
- **FSM states**
  - IDLE: able to accept a command.
  - GAP: counting `ISSUE_GAP-1` cycles after a compute issue.
  - LGAP: counting `LOAD_GAP-1` cycles after a load issue.
- **`s_ready`** is high only in IDLE and not in reset:
  - compute (`s_load`=0) requires `credit > 0`;
  - load (`s_load`=1) requires `inflight == 0`, so weights never change under a running compute.
  - `s_ready` is combinational from state, counters and `s_load`. `s_ready` must not feed back into `s_valid`.
- **Accept compute** (handshake in cycle N):
  - cycle N+1: `sa_matrix_vld`=1, `sa_we`=0, `sa_matrix` = captured `s_matrix`;
  - `inflight` increments;
  - the FSM goes to GAP, or stays in IDLE if `ISSUE_GAP`=1.
- **Accept load** (cycle N):
  - cycle N+1: `sa_we`=1, `sa_matrix_vld`=1, `sa_matrix` = captured matrix;
  - the FSM goes to LGAP.
- **GAP / LGAP** return to IDLE when the down-counter reaches 0. The first new acceptance is therefore possible exactly `ISSUE_GAP` / `LOAD_GAP` cycles after the previous acceptance.
- **`sa_matrix`** holds its last value when the valids are low. It is zero after reset.
- **Result return, `sa_res_vld`=1 with `inflight > 0`:**
  - `sa_res` is written at the buffer tail;
  - `inflight` decrements and `count` increments.
  - The buffer is guaranteed not to be full by credit accounting.
- **Result return, `sa_res_vld`=1 with `inflight == 0`:**
  - `o_err` is set;
  - the data is dropped and the counters are unchanged.
- **Buffer read:**
  - `m_valid = (count != 0)`; `m_matrix` = head entry, valid in the same cycle as `m_valid`;
  - a pop happens on `m_valid & m_ready`;
  - pointers wrap modulo `DEPTH`.
- **Simultaneous events:**
  - push and pop in the same cycle: `count` is unchanged and both pointers advance;
  - issue and push in the same cycle: `inflight` is unchanged, because the +1 and −1 cancel.
- **Reset** (any cycle, including mid-gap or with results inflight):
  - FSM → IDLE; counters, pointers, `o_err` and all outputs → 0;
  - results that arrive afterwards are flagged as unexpected.
  - It is the integrator's job to reset `sa` together with this block.

## Timing
- All outputs are registered except `s_ready`, `m_valid` and `m_matrix`. These three are combinational from registers plus `s_load`.
- **Reset values:**
  - `s_ready`=0 while `rst`=1;
  - `sa_we`, `sa_matrix_vld`, `m_valid`, `o_busy`, `o_err` = 0;
  - `sa_matrix` = 0.
- Command-to-array latency is 1 cycle.
- Array-to-`m_valid` latency is 1 cycle: a push in cycle N gives `m_valid`=1 in cycle N+1 if the buffer was empty.
- Peak compute throughput is one per `ISSUE_GAP` cycles while credit > 0.
- With `m_ready` held low, at most `DEPTH` computes are accepted.

## Test plan
- **Load, then compute:**
  - stimulus: load identity weights; after `LOAD_GAP`=8, compute matrix A = 1..16;
  - required: `sa_we` is high for exactly one cycle; the second `s_ready` is not high before 8 cycles after the first handshake; `m_matrix` equals the `sa` model result; `o_busy` returns to 0.
- **Back-pressure:**
  - stimulus: `m_ready`=0, 6 computes offered;
  - required: exactly 4 are accepted; `s_ready` stays low after that; releasing `m_ready` pops 4 results in order, then the remaining 2 are accepted.
- **Issue spacing:**
  - stimulus: continuous `s_valid` computes with `ISSUE_GAP`=4;
  - required: `sa_matrix_vld` pulses exactly every 4 cycles.
- **Load blocking:**
  - stimulus: a load is requested while `inflight`=2;
  - required: `s_ready`=0 until both results have been pushed, then the load is accepted.
- **Unexpected result:**
  - stimulus: `sa_res_vld` pulse at idle;
  - required: `o_err`=1 and stays set, `m_valid` stays 0; `rst` clears `o_err`.
- **Reset mid-operation:**
  - stimulus: `rst` during GAP with `inflight`=1 and `count`=2;
  - required: the next cycle shows `m_valid`=0, `o_busy`=0 and the FSM in IDLE.
